// File: rtl/nand_tree_pipe.sv
// Pipelined multi-lane NAND reduction with a valid/ready handshake.
// Optional statistics counters are built when NAND_TREE_PIPE_STATS_EN is defined.
module nand_tree_pipe #(
  parameter int N_IN  = 3,
  parameter int LANES = 1,
  parameter int PIPE  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*LANES-1:0] a,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      y,
  output logic [15:0]           xfer_cnt,
  output logic [15:0]           stall_cnt
);

  localparam int W = N_IN * LANES;

  // One tree level: pairs of bits are ANDed into the low half of each lane, the rest padded with ones.
  function automatic logic [W-1:0] pair_level(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '1;
    for (int l = 0; l < LANES; l++)
      for (int i = 0; i < N_IN; i++)
        r[l*N_IN + i/2] = r[l*N_IN + i/2] & d[l*N_IN + i];
    return r;
  endfunction

  function automatic logic [W-1:0] final_level(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '1;
    for (int l = 0; l < LANES; l++)
      r[l*N_IN] = ~&d[l*N_IN +: N_IN];
    return r;
  endfunction

  generate
    if (PIPE == 0) begin : g_comb
      assign in_ready  = out_ready;
      assign out_valid = in_valid;

      always_comb begin
        y = '1;
        for (int l = 0; l < LANES; l++)
          y[l] = ~&a[l*N_IN +: N_IN];
      end
    end else begin : g_pipe
      logic [PIPE:1] vld;
      logic [PIPE:1] vin;
      logic [PIPE:1] rdy;
      logic [W-1:0]  sd  [1:PIPE];
      logic [W-1:0]  nxt [1:PIPE];

      // Ready ripples back from the consumer; each stage's source is the stage before it.
      always_comb begin
        logic         chain;
        logic         vsrc;
        logic [W-1:0] src;
        rdy   = '0;
        vin   = '0;
        chain = out_ready;
        for (int s = PIPE; s >= 1; s--) begin
          chain  = ~vld[s] | chain;
          rdy[s] = chain;
        end
        vsrc = in_valid;
        src  = a;
        for (int s = 1; s <= PIPE; s++) begin
          vin[s] = vsrc;
          nxt[s] = (s == PIPE) ? final_level(src) : pair_level(src);
          vsrc   = vld[s];
          src    = sd[s];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld <= '0;
          for (int s = 1; s <= PIPE; s++)
            sd[s] <= '1;
        end else begin
          for (int s = 1; s <= PIPE; s++) begin
            if (rdy[s]) begin
              vld[s] <= vin[s];
              if (vin[s])
                sd[s] <= nxt[s];
            end
          end
        end
      end

      assign in_ready  = rdy[1];
      assign out_valid = vld[PIPE];

      // The last stage keeps the result in bit 0 of each lane with ones elsewhere, so the lane AND equals it.
      always_comb begin
        y = '1;
        for (int l = 0; l < LANES; l++)
          y[l] = &sd[PIPE][l*N_IN +: N_IN];
      end
    end
  endgenerate

`ifdef NAND_TREE_PIPE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt  <= 16'h0000;
      stall_cnt <= 16'h0000;
    end else begin
      if (out_valid && out_ready)
        xfer_cnt <= xfer_cnt + 16'd1;
      if (out_valid && !out_ready)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign xfer_cnt  = 16'h0000;
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_nand_tree_pipe.sv
// Directed and randomised checks of nand_tree_pipe across several parameter sets.
module tb_nand_tree_pipe;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic        iv1, ir1, ov1, ordy1;
  logic [2:0]  a1;
  logic [0:0]  y1;
  logic [15:0] xc1, sc1;

  logic        iv2, ir2, ov2, ordy2;
  logic [11:0] a2;
  logic [3:0]  y2;
  logic [15:0] xc2, sc2;

  logic        iv0, ir0, ov0, ordy0;
  logic [2:0]  a0;
  logic [0:0]  y0;
  logic [15:0] xc0, sc0;

  logic        iv4, ir4, ov4, ordy4;
  logic [2:0]  a4;
  logic [0:0]  y4;
  logic [15:0] xc4, sc4;

  logic        iv6, ir6, ov6, ordy6;
  logic [31:0] a6;
  logic [1:0]  y6;
  logic [15:0] xc6, sc6;

  nand_tree_pipe #(.N_IN(3), .LANES(1), .PIPE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1),
    .out_valid(ov1), .out_ready(ordy1), .y(y1), .xfer_cnt(xc1), .stall_cnt(sc1));

  nand_tree_pipe #(.N_IN(3), .LANES(4), .PIPE(3)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2),
    .out_valid(ov2), .out_ready(ordy2), .y(y2), .xfer_cnt(xc2), .stall_cnt(sc2));

  nand_tree_pipe #(.N_IN(3), .LANES(1), .PIPE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0),
    .out_valid(ov0), .out_ready(ordy0), .y(y0), .xfer_cnt(xc0), .stall_cnt(sc0));

  nand_tree_pipe #(.N_IN(3), .LANES(1), .PIPE(2)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4),
    .out_valid(ov4), .out_ready(ordy4), .y(y4), .xfer_cnt(xc4), .stall_cnt(sc4));

  nand_tree_pipe #(.N_IN(16), .LANES(2), .PIPE(4)) u6 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv6), .in_ready(ir6), .a(a6),
    .out_valid(ov6), .out_ready(ordy6), .y(y6), .xfer_cnt(xc6), .stall_cnt(sc6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] nand_model(input logic [31:0] v);
    return {~&v[31:16], ~&v[15:0]};
  endfunction

  function automatic logic [15:0] rand_lane();
    case ($urandom_range(0, 3))
      0:       return 16'hFFFF;
      1:       return ~(16'h0001 << $urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    {iv1, ordy1, iv2, ordy2, iv0, ordy0, iv4, ordy4, iv6, ordy6} = '0;
    a1 = '0; a2 = '0; a0 = '0; a4 = '0; a6 = '0;
    #12;
    rst_n = 1'b1;
    #1;
    checks++;
    if (ov1 !== 1'b0 || y1 !== 1'b1 || ir1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_u1: ov=%b y=%b ir=%b, expected ov=0 y=1 ir=1", ov1, y1, ir1);
    end
    checks++;
    if (ov2 !== 1'b0 || y2 !== 4'hF) begin
      errors++;
      $display("[TB] FAIL reset_u2: ov=%b y=%h, expected ov=0 y=f", ov2, y2);
    end
    checks++;
    if (ov4 !== 1'b0 || y4 !== 1'b1 || ov6 !== 1'b0 || y6 !== 2'b11) begin
      errors++;
      $display("[TB] FAIL reset_u4_u6: ov4=%b y4=%b ov6=%b y6=%b, expected 0 1 0 11", ov4, y4, ov6, y6);
    end
    checks++;
    if ((xc1 | sc1 | xc2 | sc2 | xc0 | sc0 | xc4 | sc4 | xc6 | sc6) !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_counters: xc1=%h sc1=%h xc2=%h sc2=%h, expected 0", xc1, sc1, xc2, sc2);
    end
  endtask

  task automatic test_identity();
    logic expY;
    tick();
    iv1 = 1'b1;
    ordy1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a1 = 3'(k);
      expY = (k == 7) ? 1'b0 : 1'b1;
      #1;
      checks++;
      if (ir1 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL id_in_ready a=%0d: got %b expected 1", k, ir1);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ov1 !== 1'b1 || y1 !== expY) begin
        errors++;
        $display("[TB] FAIL id_result a=%0d: ov=%b y=%b, expected ov=1 y=%b", k, ov1, y1, expY);
      end
    end
    iv1 = 1'b0;
    tick();
    checks++;
    if (ov1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL id_drain: ov=%b expected 0", ov1);
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] ops  [6];
    logic [3:0]  exps [6];
    int nin;
    int nout;
    ops[0] = 12'hFFF; exps[0] = 4'b0000;
    ops[1] = 12'h000; exps[1] = 4'b1111;
    ops[2] = 12'hE07; exps[2] = 4'b0110;
    ops[3] = 12'h1F8; exps[3] = 4'b1001;
    ops[4] = 12'hFC0; exps[4] = 4'b0011;
    ops[5] = 12'h03F; exps[5] = 4'b1100;
    nin  = 0;
    nout = 0;
    tick();
    for (int cyc = 0; cyc < 40 && nout < 6; cyc++) begin
      ordy2 = (cyc >= 5);
      iv2   = (nin < 6);
      if (cyc == 3 || cyc == 4)
        a2 = 12'hAAA;
      else
        a2 = (nin < 6) ? ops[nin] : 12'h000;
      #1;
      if (cyc == 3 || cyc == 4) begin
        checks++;
        if (ir2 !== 1'b0 || ov2 !== 1'b1) begin
          errors++;
          $display("[TB] FAIL bp_full cyc=%0d: ir=%b ov=%b, expected ir=0 ov=1", cyc, ir2, ov2);
        end
      end
      if (ov2 === 1'b1 && nout < 6) begin
        checks++;
        if (y2 !== exps[nout]) begin
          errors++;
          $display("[TB] FAIL bp_order cyc=%0d idx=%0d: got %b expected %b", cyc, nout, y2, exps[nout]);
        end
        if (ordy2) nout++;
      end
      if (iv2 && ir2 === 1'b1) nin++;
      @(posedge clk);
      #1;
    end
    iv2 = 1'b0;
    checks++;
    if (nout != 6 || nin != 6) begin
      errors++;
      $display("[TB] FAIL bp_count: out=%0d in=%0d, expected 6 and 6", nout, nin);
    end
  endtask

  task automatic test_passthrough();
    tick();
    a0 = 3'b110;
    iv0 = 1'b1;
    ordy0 = 1'b0;
    #1;
    checks++;
    if (y0 !== 1'b1 || ov0 !== 1'b1 || ir0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pt_stall: y=%b ov=%b ir=%b, expected y=1 ov=1 ir=0", y0, ov0, ir0);
    end
    a0 = 3'b111;
    ordy0 = 1'b1;
    #1;
    checks++;
    if (y0 !== 1'b0 || ir0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pt_ones: y=%b ir=%b, expected y=0 ir=1", y0, ir0);
    end
    iv0 = 1'b0;
    #1;
    checks++;
    if (ov0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pt_invalid: ov=%b expected 0", ov0);
    end
  endtask

  task automatic test_mid_reset();
    tick();
    ordy4 = 1'b0;
    iv4 = 1'b1;
    a4 = 3'b111;
    tick();
    a4 = 3'b011;
    tick();
    iv4 = 1'b0;
    checks++;
    if (ov4 !== 1'b1 || y4 !== 1'b0 || ir4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mr_inflight: ov=%b y=%b ir=%b, expected ov=1 y=0 ir=0", ov4, y4, ir4);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov4 !== 1'b0 || y4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mr_async: ov=%b y=%b, expected ov=0 y=1", ov4, y4);
    end
    #1;
    rst_n = 1'b1;
    tick();
    iv4 = 1'b1;
    a4 = 3'b101;
    ordy4 = 1'b1;
    tick();
    iv4 = 1'b0;
    checks++;
    if (ov4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mr_latency: ov=%b expected 0", ov4);
    end
    tick();
    checks++;
    if (ov4 !== 1'b1 || y4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mr_first: ov=%b y=%b, expected ov=1 y=1", ov4, y4);
    end
    tick();
    checks++;
    if (ov4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mr_no_stale: ov=%b expected 0", ov4);
    end
  endtask

  task automatic test_width_sweep();
    logic [1:0] q[$];
    logic [1:0] expY;
    int w;
    tick();
    ordy6 = 1'b1;
    iv6 = 1'b1;
    a6 = {16'hFFFE, 16'hFFFF};
    tick();
    iv6 = 1'b0;
    w = 0;
    while (ov6 !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    checks++;
    if (ov6 !== 1'b1 || y6 !== 2'b10) begin
      errors++;
      $display("[TB] FAIL ws_directed: ov=%b y=%b, expected ov=1 y=10", ov6, y6);
    end
    tick();
    for (int cyc = 0; cyc < 10020; cyc++) begin
      if (cyc < 10000) begin
        iv6   = 1'($urandom_range(0, 1));
        ordy6 = ($urandom_range(0, 3) != 0);
        a6    = {rand_lane(), rand_lane()};
      end else begin
        iv6   = 1'b0;
        ordy6 = 1'b1;
      end
      #1;
      if (ov6 === 1'b1 && ordy6) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("[TB] FAIL ws_extra cyc=%0d: got y=%b with no result expected", cyc, y6);
        end else begin
          expY = q.pop_front();
          if (y6 !== expY) begin
            errors++;
            $display("[TB] FAIL ws_random cyc=%0d: got %b expected %b", cyc, y6, expY);
          end
        end
      end
      if (iv6 && ir6 === 1'b1) q.push_back(nand_model(a6));
      @(posedge clk);
      #1;
    end
    checks++;
    if (q.size() != 0 || ov6 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ws_drain: %0d results outstanding, ov=%b, expected 0 and 0", q.size(), ov6);
    end
  endtask

  task automatic test_stats();
    logic [15:0] expXfer;
    logic [15:0] expStall;
`ifdef NAND_TREE_PIPE_STATS_EN
    expXfer  = 16'd4464;
    expStall = 16'd3;
`else
    expXfer  = 16'd0;
    expStall = 16'd0;
`endif
    tick();
    rst_n = 1'b0;
    a1 = 3'b010;
    iv1 = 1'b1;
    ordy1 = 1'b1;
    #2;
    rst_n = 1'b1;
    repeat (70001) @(posedge clk);
    #1;
    ordy1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (xc1 !== expXfer) begin
      errors++;
      $display("[TB] FAIL stats_xfer: got %0d expected %0d", xc1, expXfer);
    end
    checks++;
    if (sc1 !== expStall) begin
      errors++;
      $display("[TB] FAIL stats_stall: got %0d expected %0d", sc1, expStall);
    end
    checks++;
    if (ov1 !== 1'b1 || y1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stats_hold: ov=%b y=%b, expected ov=1 y=1", ov1, y1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_identity();
    test_backpressure();
    test_passthrough();
    test_mid_reset();
    test_width_sweep();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
